// File: rtl/Purple_Jade_pkg.sv
// Shared types and constants for the load/store execute unit.
// Holds the operation record, the writeback payload, the store-packet width,
// plus helpers for address generation and saturating performance counters.
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P  = 16;
  localparam int NUM_PHYS_REG = 32;
  localparam int ROB_ENTRY    = 16;
  localparam int SB_ENTRY     = 8;
  localparam int IMM_W        = 8;

  localparam int PREG_W       = $clog2(NUM_PHYS_REG);
  localparam int ROB_W        = $clog2(ROB_ENTRY);
  localparam int SB_W         = $clog2(SB_ENTRY);

  // {sb_num, addr, data}, MSB first
  localparam int CDB_SB_WIDTH = SB_W + 2 * WORD_SIZE_P;
  localparam int LSU_PERF_W   = 16;

  typedef struct packed {
    logic                   is_st;
    logic [WORD_SIZE_P-1:0] addr;
    logic [WORD_SIZE_P-1:0] data;
    logic [PREG_W-1:0]      dst;
    logic [ROB_W-1:0]       rob;
    logic [SB_W-1:0]        sb;
  } lsu_op_t;

  typedef struct packed {
    logic [PREG_W-1:0]      dst;
    logic [ROB_W-1:0]       rob;
    logic [WORD_SIZE_P-1:0] data;
  } lsu_wb_t;

  // Effective address: base plus sign-extended offset, wrapping modulo 2^WORD_SIZE_P.
  function automatic logic [WORD_SIZE_P-1:0] lsu_agen(
    input logic [WORD_SIZE_P-1:0] base,
    input logic [IMM_W-1:0]       imm
  );
    return base + {{(WORD_SIZE_P-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  // Increment when enabled, sticking at all-ones.
  function automatic logic [LSU_PERF_W-1:0] perf_inc(
    input logic [LSU_PERF_W-1:0] cnt,
    input logic                  en
  );
    if (en && (cnt != {LSU_PERF_W{1'b1}})) begin
      return cnt + LSU_PERF_W'(1);
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/lsu_wb_reg.sv
// One-entry valid/ready pipeline register with flush.
// Accepts a new entry whenever it is empty or its current entry drains in the
// same cycle; flush has priority and empties the stage.
module lsu_wb_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         in_v_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_v_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o = !v_q || out_ready_i;
  assign out_v_o    = v_q;
  assign out_data_o = data_q;

  // Next-state: flush empties, push loads, a bare drain empties.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (in_v_i && in_ready_o) begin
      v_d    = 1'b1;
      data_d = in_data_i;
    end else if (out_ready_i) begin
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/lsu_exe.sv
// Load/store execute unit.
// S1 holds the issued op with its generated address. Stores leave S1 as a
// store-buffer packet in the same cycle. Loads look up memory and the
// store-buffer bypass port, then move into S2 (lsu_wb_reg), which drives the CDB.
// Optional feature macro: LSU_PERF_CNT_EN (saturating performance counters).
module lsu_exe
  import Purple_Jade_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    issue_lsu_v_i,
  output logic                    lsu_issue_ready_o,
  input  logic                    issue_is_st_i,
  input  logic [WORD_SIZE_P-1:0]  issue_base_i,
  input  logic [IMM_W-1:0]        issue_imm_i,
  input  logic [WORD_SIZE_P-1:0]  issue_st_data_i,
  input  logic [PREG_W-1:0]       issue_dst_i,
  input  logic [ROB_W-1:0]        issue_rob_i,
  input  logic [SB_W-1:0]         issue_sb_i,
  output logic                    exe_sb_v_o,
  output logic [CDB_SB_WIDTH-1:0] exe_sb_o,
  output logic [WORD_SIZE_P-1:0]  exe_mem_addr_o,
  input  logic [WORD_SIZE_P-1:0]  exe_mem_data_i,
  output logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_o,
  output logic [SB_W-1:0]         exe_ld_bypass_sb_num_o,
  input  logic                    sb_ld_bypass_valid_i,
  input  logic [WORD_SIZE_P-1:0]  sb_ld_bypass_value_i,
  output logic                    cdb_v_o,
  input  logic                    cdb_ready_i,
  output logic [PREG_W-1:0]       cdb_dst_o,
  output logic [ROB_W-1:0]        cdb_rob_o,
  output logic [WORD_SIZE_P-1:0]  cdb_data_o,
`ifdef LSU_PERF_CNT_EN
  output logic [LSU_PERF_W-1:0]   perf_ld_o,
  output logic [LSU_PERF_W-1:0]   perf_st_o,
  output logic [LSU_PERF_W-1:0]   perf_byp_o,
  output logic [LSU_PERF_W-1:0]   perf_stall_o,
`endif
  input  logic                    rob_mispredict_i
);

  lsu_op_t                s1_q, s1_d;
  logic                   s1_v_q, s1_v_d;
  lsu_op_t                new_op;
  logic                   s1_ld, s1_adv, issue_fire;
  logic                   s2_in_ready, s2_v;
  lsu_wb_t                s2_in, s2_out;
  logic [WORD_SIZE_P-1:0] ld_data;
  logic [WORD_SIZE_P-1:0] mem_addr_q, mem_addr_d;
  logic [SB_W-1:0]        byp_sb_q, byp_sb_d;

  // Stores always leave S1; a load leaves only if S2 can take it.
  assign s1_ld             = s1_v_q && !s1_q.is_st;
  assign s1_adv            = s1_v_q && (s1_q.is_st || s2_in_ready);
  assign lsu_issue_ready_o = !s1_v_q || s1_adv;
  assign issue_fire        = issue_lsu_v_i && lsu_issue_ready_o;

  // Build the S1 record for the op presented on the issue port.
  always_comb begin
    new_op       = '0;
    new_op.is_st = issue_is_st_i;
    new_op.addr  = lsu_agen(issue_base_i, issue_imm_i);
    new_op.data  = issue_st_data_i;
    new_op.dst   = issue_dst_i;
    new_op.rob   = issue_rob_i;
    new_op.sb    = issue_sb_i;
  end

  // S1 next state: flush drops everything including a same-cycle issue.
  always_comb begin
    s1_v_d = s1_v_q;
    s1_d   = s1_q;
    if (rob_mispredict_i) begin
      s1_v_d = 1'b0;
    end else if (issue_fire) begin
      s1_v_d = 1'b1;
      s1_d   = new_op;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // Lookup address/sb number follow the S1 load and otherwise keep their last value.
  always_comb begin
    mem_addr_d = mem_addr_q;
    byp_sb_d   = byp_sb_q;
    if (s1_ld) begin
      mem_addr_d = s1_q.addr;
      byp_sb_d   = s1_q.sb;
    end else begin
      mem_addr_d = mem_addr_q;
      byp_sb_d   = byp_sb_q;
    end
  end

  // S1 register and lookup-hold registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q     <= 1'b0;
      s1_q       <= '0;
      mem_addr_q <= '0;
      byp_sb_q   <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_q       <= s1_d;
      mem_addr_q <= mem_addr_d;
      byp_sb_q   <= byp_sb_d;
    end
  end

  assign exe_mem_addr_o         = mem_addr_d;
  assign exe_ld_bypass_addr_o   = mem_addr_d;
  assign exe_ld_bypass_sb_num_o = byp_sb_d;

  // A store-buffer hit overrides memory data.
  assign ld_data = sb_ld_bypass_valid_i ? sb_ld_bypass_value_i : exe_mem_data_i;

  assign exe_sb_v_o = s1_v_q && s1_q.is_st && !rob_mispredict_i;
  assign exe_sb_o   = {s1_q.sb, s1_q.addr, s1_q.data};

  assign s2_in.dst  = s1_q.dst;
  assign s2_in.rob  = s1_q.rob;
  assign s2_in.data = ld_data;

  lsu_wb_reg #(
    .W($bits(lsu_wb_t))
  ) u_s2 (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (rob_mispredict_i),
    .in_v_i     (s1_ld),
    .in_ready_o (s2_in_ready),
    .in_data_i  (s2_in),
    .out_v_o    (s2_v),
    .out_ready_i(cdb_ready_i),
    .out_data_o (s2_out)
  );

  assign cdb_v_o    = s2_v && !rob_mispredict_i;
  assign cdb_dst_o  = s2_out.dst;
  assign cdb_rob_o  = s2_out.rob;
  assign cdb_data_o = s2_out.data;

`ifdef LSU_PERF_CNT_EN
  logic [LSU_PERF_W-1:0] perf_ld_q, perf_st_q, perf_byp_q, perf_stall_q;
  logic                  byp_hit_s;

  assign byp_hit_s = s1_ld && s2_in_ready && sb_ld_bypass_valid_i && !rob_mispredict_i;

  // Saturating event counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_ld_q    <= '0;
      perf_st_q    <= '0;
      perf_byp_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ld_q    <= perf_inc(perf_ld_q, cdb_v_o && cdb_ready_i);
      perf_st_q    <= perf_inc(perf_st_q, exe_sb_v_o);
      perf_byp_q   <= perf_inc(perf_byp_q, byp_hit_s);
      perf_stall_q <= perf_inc(perf_stall_q, s1_ld && !s2_in_ready);
    end
  end

  assign perf_ld_o    = perf_ld_q;
  assign perf_st_o    = perf_st_q;
  assign perf_byp_o   = perf_byp_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_lsu_exe.sv
// Self-checking bench for lsu_exe: directed latency/stall/flush cases, then
// randomized traffic checked against a transaction-level reference model.
module tb_lsu_exe;
  import Purple_Jade_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    reset_i;
  logic                    issue_lsu_v_i;
  logic                    lsu_issue_ready_o;
  logic                    issue_is_st_i;
  logic [WORD_SIZE_P-1:0]  issue_base_i;
  logic [IMM_W-1:0]        issue_imm_i;
  logic [WORD_SIZE_P-1:0]  issue_st_data_i;
  logic [PREG_W-1:0]       issue_dst_i;
  logic [ROB_W-1:0]        issue_rob_i;
  logic [SB_W-1:0]         issue_sb_i;
  logic                    exe_sb_v_o;
  logic [CDB_SB_WIDTH-1:0] exe_sb_o;
  logic [WORD_SIZE_P-1:0]  exe_mem_addr_o;
  logic [WORD_SIZE_P-1:0]  exe_mem_data_i;
  logic [WORD_SIZE_P-1:0]  exe_ld_bypass_addr_o;
  logic [SB_W-1:0]         exe_ld_bypass_sb_num_o;
  logic                    sb_ld_bypass_valid_i;
  logic [WORD_SIZE_P-1:0]  sb_ld_bypass_value_i;
  logic                    cdb_v_o;
  logic                    cdb_ready_i;
  logic [PREG_W-1:0]       cdb_dst_o;
  logic [ROB_W-1:0]        cdb_rob_o;
  logic [WORD_SIZE_P-1:0]  cdb_data_o;
  logic                    rob_mispredict_i;
`ifdef LSU_PERF_CNT_EN
  logic [LSU_PERF_W-1:0]   perf_ld_o, perf_st_o, perf_byp_o, perf_stall_o;
`endif

  lsu_exe dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .issue_lsu_v_i         (issue_lsu_v_i),
    .lsu_issue_ready_o     (lsu_issue_ready_o),
    .issue_is_st_i         (issue_is_st_i),
    .issue_base_i          (issue_base_i),
    .issue_imm_i           (issue_imm_i),
    .issue_st_data_i       (issue_st_data_i),
    .issue_dst_i           (issue_dst_i),
    .issue_rob_i           (issue_rob_i),
    .issue_sb_i            (issue_sb_i),
    .exe_sb_v_o            (exe_sb_v_o),
    .exe_sb_o              (exe_sb_o),
    .exe_mem_addr_o        (exe_mem_addr_o),
    .exe_mem_data_i        (exe_mem_data_i),
    .exe_ld_bypass_addr_o  (exe_ld_bypass_addr_o),
    .exe_ld_bypass_sb_num_o(exe_ld_bypass_sb_num_o),
    .sb_ld_bypass_valid_i  (sb_ld_bypass_valid_i),
    .sb_ld_bypass_value_i  (sb_ld_bypass_value_i),
    .cdb_v_o               (cdb_v_o),
    .cdb_ready_i           (cdb_ready_i),
    .cdb_dst_o             (cdb_dst_o),
    .cdb_rob_o             (cdb_rob_o),
    .cdb_data_o            (cdb_data_o),
`ifdef LSU_PERF_CNT_EN
    .perf_ld_o             (perf_ld_o),
    .perf_st_o             (perf_st_o),
    .perf_byp_o            (perf_byp_o),
    .perf_stall_o          (perf_stall_o),
`endif
    .rob_mispredict_i      (rob_mispredict_i)
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory / store-buffer environment: fixed values in directed mode,
  // address-derived functions in random mode.
  logic                   rand_mode;
  logic [WORD_SIZE_P-1:0] mem_val, byp_val;
  logic                   byp_vld;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return ~a ^ 16'h5A00;
  endfunction
  function automatic logic byp_hit_fn(input logic [15:0] a, input logic [2:0] s);
    return ^{a[3:0], s[0]};
  endfunction
  function automatic logic [15:0] byp_val_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  assign exe_mem_data_i       = rand_mode ? mem_fn(exe_mem_addr_o) : mem_val;
  assign sb_ld_bypass_valid_i = rand_mode ? byp_hit_fn(exe_ld_bypass_addr_o, exe_ld_bypass_sb_num_o) : byp_vld;
  assign sb_ld_bypass_value_i = rand_mode ? byp_val_fn(exe_ld_bypass_addr_o) : byp_val;

  // Reference address: plain integer arithmetic, wrapped to 16 bits.
  function automatic logic [15:0] ref_addr(input logic [15:0] base, input logic [7:0] imm);
    int s;
    s = int'(base) + int'($signed(imm));
    return s[15:0];
  endfunction

  typedef struct {
    logic [4:0]  dst;
    logic [3:0]  rob;
    logic [15:0] data;
  } ld_exp_t;

  ld_exp_t     lq[$];
  logic [34:0] sq[$];
  logic        hold_pend;
  ld_exp_t     held;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic drive_op(input logic st, input logic [15:0] base, input logic [7:0] imm,
                          input logic [15:0] data, input logic [4:0] dst,
                          input logic [3:0] rob, input logic [2:0] sb);
    issue_lsu_v_i   = 1'b1;
    issue_is_st_i   = st;
    issue_base_i    = base;
    issue_imm_i     = imm;
    issue_st_data_i = data;
    issue_dst_i     = dst;
    issue_rob_i     = rob;
    issue_sb_i      = sb;
  endtask

  // One randomized cycle: drive, sample at negedge, check against the model.
  task automatic rand_step(input bit drain);
    ld_exp_t e;
    logic [15:0] a;
    if (drain) begin
      issue_lsu_v_i    = 1'b0;
      cdb_ready_i      = 1'b1;
      rob_mispredict_i = 1'b0;
    end else begin
      drive_op(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 16'($urandom),
               5'($urandom), 4'($urandom), 3'($urandom));
      issue_lsu_v_i    = ($urandom_range(0, 9) < 7);
      cdb_ready_i      = ($urandom_range(0, 9) < 7);
      rob_mispredict_i = ($urandom_range(0, 99) < 3);
    end
    smp();
    if (rob_mispredict_i) begin
      check_eq("flush_sb_v", exe_sb_v_o, 1'b0);
      check_eq("flush_cdb_v", cdb_v_o, 1'b0);
      lq.delete();
      sq.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check_eq("hold_v", cdb_v_o, 1'b1);
        check_eq("hold_payload", {cdb_dst_o, cdb_rob_o, cdb_data_o}, {held.dst, held.rob, held.data});
      end
      if (exe_sb_v_o) begin
        if (sq.size() == 0) check_eq("sb_unexpected", exe_sb_v_o, 1'b0);
        else check_eq("sb_pkt", exe_sb_o, sq.pop_front());
      end
      if (cdb_v_o && cdb_ready_i) begin
        if (lq.size() == 0) check_eq("cdb_unexpected", cdb_v_o, 1'b0);
        else begin
          e = lq.pop_front();
          check_eq("cdb_payload", {cdb_dst_o, cdb_rob_o, cdb_data_o}, {e.dst, e.rob, e.data});
        end
      end
      hold_pend = cdb_v_o && !cdb_ready_i;
      held.dst  = cdb_dst_o;
      held.rob  = cdb_rob_o;
      held.data = cdb_data_o;
      if (issue_lsu_v_i && lsu_issue_ready_o) begin
        a = ref_addr(issue_base_i, issue_imm_i);
        if (issue_is_st_i) begin
          sq.push_back({issue_sb_i, a, issue_st_data_i});
        end else begin
          e.dst  = issue_dst_i;
          e.rob  = issue_rob_i;
          e.data = byp_hit_fn(a, issue_sb_i) ? byp_val_fn(a) : mem_fn(a);
          lq.push_back(e);
        end
      end
    end
    tick();
  endtask

  initial begin
    reset_i          = 1'b1;
    rand_mode        = 1'b0;
    mem_val          = 16'h0000;
    byp_val          = 16'h0000;
    byp_vld          = 1'b0;
    cdb_ready_i      = 1'b1;
    rob_mispredict_i = 1'b0;
    hold_pend        = 1'b0;
    drive_op(1'b0, 16'h0000, 8'h00, 16'h0000, 5'd0, 4'd0, 3'd0);
    issue_lsu_v_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Reset state
    smp();
    check_eq("rst_ready", lsu_issue_ready_o, 1'b1);
    check_eq("rst_sb_v", exe_sb_v_o, 1'b0);
    check_eq("rst_sb_pkt", exe_sb_o, 35'd0);
    check_eq("rst_cdb_v", cdb_v_o, 1'b0);
    check_eq("rst_cdb", {cdb_dst_o, cdb_rob_o, cdb_data_o}, 25'd0);
    check_eq("rst_mem_addr", exe_mem_addr_o, 16'h0000);

    // Load with negative offset, no bypass
    tick();
    mem_val = 16'hBEEF;
    drive_op(1'b0, 16'h0100, 8'hFE, 16'h0000, 5'd5, 4'd7, 3'd0);
    tick();
    issue_lsu_v_i = 1'b0;
    smp();
    check_eq("ld1_mem_addr", exe_mem_addr_o, 16'h00FE);
    check_eq("ld1_byp_addr", exe_ld_bypass_addr_o, 16'h00FE);
    check_eq("ld1_cdb_early", cdb_v_o, 1'b0);
    tick();
    smp();
    check_eq("ld1_cdb_v", cdb_v_o, 1'b1);
    check_eq("ld1_cdb", {cdb_dst_o, cdb_rob_o, cdb_data_o}, {5'd5, 4'd7, 16'hBEEF});
    tick();

    // Store with address wrap
    drive_op(1'b1, 16'hFFFF, 8'h01, 16'h1234, 5'd0, 4'd1, 3'd3);
    tick();
    issue_lsu_v_i = 1'b0;
    smp();
    check_eq("st_sb_v", exe_sb_v_o, 1'b1);
    check_eq("st_pkt", exe_sb_o, {3'd3, 16'h0000, 16'h1234});
    tick();
    smp();
    check_eq("st_sb_v_clr", exe_sb_v_o, 1'b0);

    // Load served by the store-buffer bypass
    byp_vld = 1'b1;
    byp_val = 16'h5A5A;
    mem_val = 16'h0000;
    tick();
    drive_op(1'b0, 16'h0200, 8'h10, 16'h0000, 5'd9, 4'd2, 3'd6);
    tick();
    issue_lsu_v_i = 1'b0;
    smp();
    check_eq("byp_sb_num", exe_ld_bypass_sb_num_o, 3'd6);
    check_eq("byp_addr", exe_ld_bypass_addr_o, 16'h0210);
    tick();
    smp();
    check_eq("byp_cdb_v", cdb_v_o, 1'b1);
    check_eq("byp_cdb_data", cdb_data_o, 16'h5A5A);
    tick();
    byp_vld = 1'b0;
    smp();
`ifdef LSU_PERF_CNT_EN
    check_eq("perf_ld", perf_ld_o, 16'd2);
    check_eq("perf_st", perf_st_o, 16'd1);
    check_eq("perf_byp", perf_byp_o, 16'd1);
    check_eq("perf_stall", perf_stall_o, 16'd0);
`endif

    // Back-to-back loads with CDB back-pressure
    tick();
    cdb_ready_i = 1'b0;
    mem_val     = 16'h1111;
    drive_op(1'b0, 16'h0010, 8'h00, 16'h0000, 5'd1, 4'd1, 3'd0);
    tick();
    drive_op(1'b0, 16'h0020, 8'h00, 16'h0000, 5'd2, 4'd2, 3'd0);
    smp();
    check_eq("b2b_ready_2nd", lsu_issue_ready_o, 1'b1);
    tick();
    issue_lsu_v_i = 1'b0;
    mem_val       = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      smp();
      check_eq("b2b_hold_v", cdb_v_o, 1'b1);
      check_eq("b2b_hold", {cdb_dst_o, cdb_data_o}, {5'd1, 16'h1111});
      check_eq("b2b_ready_lo", lsu_issue_ready_o, 1'b0);
      tick();
    end
    cdb_ready_i = 1'b1;
    smp();
    check_eq("b2b_a", {cdb_v_o, cdb_dst_o, cdb_data_o}, {1'b1, 5'd1, 16'h1111});
    tick();
    smp();
    check_eq("b2b_b", {cdb_v_o, cdb_dst_o, cdb_data_o}, {1'b1, 5'd2, 16'h2222});
    tick();
    smp();
    check_eq("b2b_done", cdb_v_o, 1'b0);

    // Mispredict with store in S1 and load in S2
    tick();
    cdb_ready_i = 1'b0;
    drive_op(1'b0, 16'h0030, 8'h00, 16'h0000, 5'd3, 4'd3, 3'd0);
    tick();
    drive_op(1'b1, 16'h0040, 8'h00, 16'h7777, 5'd0, 4'd4, 3'd1);
    tick();
    issue_lsu_v_i    = 1'b0;
    rob_mispredict_i = 1'b1;
    smp();
    check_eq("mp_sb_v", exe_sb_v_o, 1'b0);
    check_eq("mp_cdb_v", cdb_v_o, 1'b0);
    tick();
    rob_mispredict_i = 1'b0;
    cdb_ready_i      = 1'b1;
    smp();
    check_eq("mp_after", {exe_sb_v_o, cdb_v_o, lsu_issue_ready_o}, 3'b001);
    tick();
    smp();
    check_eq("mp_after2", {exe_sb_v_o, cdb_v_o}, 2'b00);

    // Reset while a load is in flight
    tick();
    drive_op(1'b0, 16'h0050, 8'h00, 16'h0000, 5'd4, 4'd5, 3'd0);
    tick();
    issue_lsu_v_i = 1'b0;
    reset_i       = 1'b1;
    #2 reset_i    = 1'b0;
    smp();
    check_eq("mrst_state", {exe_sb_v_o, cdb_v_o, lsu_issue_ready_o}, 3'b001);
    tick();
    smp();
    check_eq("mrst_cdb_v", cdb_v_o, 1'b0);
    tick();

    // Randomized traffic, then drain
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) rand_step(1'b0);
    for (int i = 0; i < 20; i++) rand_step(1'b1);
    check_eq("lq_empty", lq.size(), 0);
    check_eq("sq_empty", sq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
